// File: rtl/mem_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_ctrl
// Description : Streams bytes into a synchronous RAM from address 0 and reads
//               the stored block back out through a 2-entry skid buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_load,
    input  logic              start_read,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_d_i,
    input  logic [DATA_W-1:0] mem_d_o
);

    localparam logic [ADDR_W:0] c_last_addr = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] c_one       = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_READ = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_in_ready;
    logic                r_done;
    logic [ADDR_W:0]     r_count;
    logic [ADDR_W:0]     r_wptr;
    logic [ADDR_W:0]     r_rptr;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [DATA_W-1:0]   r_buf_data [2];
    logic [1:0]          r_buf_last;
    logic                r_head;
    logic [1:0]          r_occ;

    logic                w_wr;
    logic                w_wr_end;
    logic                w_pop;
    logic                w_issue;
    logic                w_tail;
    logic                w_read_end;
    logic [1:0]          w_slots;

    assign w_wr     = (r_state == S_LOAD) && in_valid && r_in_ready;
    assign w_wr_end = w_wr && (in_last || (r_wptr == c_last_addr));

    assign w_pop    = out_valid && out_ready;
    // A pop in the same cycle frees a slot, which keeps full-rate streaming bubble-free.
    assign w_slots  = r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue  = (r_state == S_READ) && (r_rptr < r_count) && (w_slots < 2'd2);
    assign w_tail   = r_head ^ r_occ[0];
    assign w_read_end = (r_state == S_READ) &&
                        ((r_count == '0) || (w_pop && r_buf_last[r_head]));

    assign in_ready  = r_in_ready;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_buf_data[r_head];
    assign out_last  = out_valid && r_buf_last[r_head];
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign count     = r_count;
    assign mem_wr    = w_wr;
    assign mem_d_i   = in_data;
    assign mem_addr  = w_wr    ? r_wptr[ADDR_W-1:0] :
                       w_issue ? r_rptr[ADDR_W-1:0] : r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_in_ready      <= 1'b0;
            r_done          <= 1'b0;
            r_count         <= '0;
            r_wptr          <= '0;
            r_rptr          <= '0;
            r_addr          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_buf_data[0]   <= '0;
            r_buf_data[1]   <= '0;
            r_buf_last      <= '0;
            r_head          <= 1'b0;
            r_occ           <= '0;
        end else begin
            r_done     <= 1'b0;
            r_inflight <= w_issue;

            if (w_wr) begin
                r_wptr  <= r_wptr + c_one;
                r_count <= r_wptr + c_one;
                r_addr  <= r_wptr[ADDR_W-1:0];
            end

            if (w_issue) begin
                r_rptr          <= r_rptr + c_one;
                r_addr          <= r_rptr[ADDR_W-1:0];
                r_inflight_last <= (r_rptr == r_count - c_one);
            end

            // RAM data for last cycle's issue lands in the buffer tail now.
            if (r_inflight) begin
                r_buf_data[w_tail] <= mem_d_o;
                r_buf_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};

            case (r_state)
                S_IDLE: begin
                    if (start_load) begin
                        r_state    <= S_LOAD;
                        r_in_ready <= 1'b1;
                        r_wptr     <= '0;
                        r_count    <= '0;
                    end else if (start_read) begin
                        r_state    <= S_READ;
                        r_rptr     <= '0;
                        r_head     <= 1'b0;
                        r_occ      <= '0;
                        r_inflight <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_wr_end) begin
                        r_state    <= S_IDLE;
                        r_in_ready <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                S_READ: begin
                    if (w_read_end) begin
                        r_state    <= S_IDLE;
                        r_done     <= 1'b1;
                        r_head     <= 1'b0;
                        r_occ      <= '0;
                        r_inflight <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stream_ctrl
// Description : Directed self-checking bench for mem_stream_ctrl with a RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stream_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_load = 1'b0;
    logic       start_read = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       busy;
    logic       done;
    logic [10:0] count;
    logic       mem_wr;
    logic [9:0] mem_addr;
    logic [7:0] mem_d_i;
    logic [7:0] mem_d_o;

    logic [7:0] ram [1024];

    int n_err = 0;
    int n_chk = 0;

    mem_stream_ctrl #(.DATA_W(8), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_load (start_load),
        .start_read (start_read),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done),
        .count      (count),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_d_i    (mem_d_i),
        .mem_d_o    (mem_d_o)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: one-cycle read latency, read-before-write.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_addr] <= mem_d_i;
        mem_d_o <= ram[mem_addr];
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [8:0] rx [8];
        int         n_rx;
        logic       hold;
        logic [7:0] held;
        logic       got_done;
        int         first_c, last_c, done_c;

        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;

        // Reset state
        tick; tick;
        rst = 1'b0;
        #1;
        check_val("reset_outs", {in_ready, out_valid, out_last, busy, done, mem_wr}, 6'b0);
        check_val("reset_count", count, 0);

        // Read with count==0: done one cycle after entering READ, never out_valid
        start_read = 1'b1;
        tick;
        start_read = 1'b0;
        #1;
        check_val("rd0_enter", {busy, out_valid, done}, 3'b100);
        tick; #1;
        check_val("rd0_done", {busy, out_valid, done}, 3'b001);
        tick; #1;
        check_val("rd0_after", {busy, out_valid, done}, 3'b000);

        // Simultaneous starts: LOAD wins; start_read mid-load is ignored
        start_load = 1'b1;
        start_read = 1'b1;
        tick;
        start_load = 1'b0;
        start_read = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_data    = 8'h11 + 8'(i);
            in_last    = (i == 4);
            start_read = (i == 2);
            #1;
            check_val("ld5_wr", {in_ready, mem_wr, mem_addr}, {1'b1, 1'b1, 10'(i)});
            tick;
        end
        in_valid   = 1'b0;
        in_last    = 1'b0;
        start_read = 1'b0;
        #1;
        check_val("ld5_end", {done, in_ready, busy}, 3'b100);
        check_val("ld5_count", count, 5);
        tick; #1;
        check_val("ld5_done_once", {done, in_ready}, 2'b00);
        for (int i = 0; i < 5; i++) check_val("ld5_ram", ram[i], 32'h11 + 32'(i));

        // Readback at full rate: data on t+3..t+7, done on t+8
        out_ready  = 1'b1;
        start_read = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            logic [10:0] exp;
            tick;
            start_read = 1'b0;
            #1;
            if (k >= 3 && k <= 7) exp = {1'b0, 1'b1, (k == 7), 8'h11 + 8'(k - 3)};
            else                  exp = {(k == 8), 2'b00, 8'h00};
            check_val("rd5_cycle", {done, out_valid, out_last, (out_valid ? out_data : 8'h00)}, 32'(exp));
        end

        // Readback with out_ready pattern 1,0,0,1
        out_ready  = 1'b0;
        start_read = 1'b1;
        tick;
        start_read = 1'b0;
        n_rx = 0; hold = 1'b0; held = 8'h00; got_done = 1'b0;
        for (int c = 0; c < 60 && !got_done; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            #1;
            if (hold) check_val("tog_hold", {out_valid, out_data}, {1'b1, held});
            if (out_valid && out_ready) begin
                if (n_rx < 8) rx[n_rx] = {out_last, out_data};
                n_rx++;
            end
            hold = out_valid && !out_ready;
            held = out_data;
            if (done) got_done = 1'b1;
            tick;
        end
        check_val("tog_done", got_done, 1);
        check_val("tog_n", n_rx, 5);
        for (int i = 0; i < 5 && i < n_rx; i++)
            check_val("tog_byte", rx[i], {(i == 4), 8'h11 + 8'(i)});

        // Load 1024 bytes without in_last: stops at full
        out_ready  = 1'b0;
        start_load = 1'b1;
        tick;
        start_load = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            in_valid = 1'b1;
            in_data  = i[7:0];
            in_last  = 1'b0;
            #1;
            if (i == 0 || i == 512 || i == 1023)
                check_val("ld1k_wr", {in_ready, mem_wr, mem_addr}, {1'b1, 1'b1, 10'(i)});
            tick;
        end
        in_data = 8'hAA;
        #1;
        check_val("ld1k_full", {done, in_ready, mem_wr, busy}, 4'b1000);
        check_val("ld1k_count", count, 1024);
        tick;
        in_valid = 1'b0;
        check_val("ld1k_ram_1023", ram[1023], 8'hFF);
        check_val("ld1k_ram_300", ram[300], 8'h2C);
        check_val("ld1k_ram_4", ram[4], 8'h04);

        // Readback of 1024 bytes at full rate
        out_ready  = 1'b1;
        start_read = 1'b1;
        tick;
        start_read = 1'b0;
        n_rx = 0; got_done = 1'b0; first_c = -1; last_c = -1; done_c = -1;
        for (int c = 1; c < 1100 && !got_done; c++) begin
            #1;
            if (out_valid) begin
                if (first_c < 0) first_c = c;
                if (n_rx == 0 || n_rx == 1023 || (n_rx % 97 == 0) || out_last)
                    check_val("rd1k_byte", {out_last, out_data}, {(n_rx == 1023), n_rx[7:0]});
                else if (out_data !== n_rx[7:0])
                    check_val("rd1k_byte", out_data, n_rx[7:0]);
                if (out_last) last_c = c;
                n_rx++;
            end
            if (done) begin
                got_done = 1'b1;
                done_c = c;
            end
            tick;
        end
        check_val("rd1k_n", n_rx, 1024);
        check_val("rd1k_first", first_c, 3);
        check_val("rd1k_last", last_c, 1026);
        check_val("rd1k_done", done_c, 1027);

        // Reset mid-read after 3 bytes
        start_read = 1'b1;
        tick;
        start_read = 1'b0;
        n_rx = 0;
        for (int c = 0; c < 20; c++) begin
            #1;
            if (out_valid) n_rx++;
            if (n_rx == 3) break;
            tick;
        end
        check_val("rst_mid_n", n_rx, 3);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        #1;
        check_val("rst_mid_outs", {out_valid, busy, done}, 3'b000);
        check_val("rst_mid_count", count, 0);
        tick; #1;
        check_val("rst_mid_nodone", {out_valid, busy, done}, 3'b000);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stream_ctrl.md
Name: mem_stream_ctrl

Overview:
- Sequencing stage directly upstream and downstream of the 8x1024 synchronous RAM.
- Accepts a valid/ready byte stream and writes it sequentially into the RAM from address 0.
- On command, reads the stored block back out as a valid/ready stream.
- Absorbs the RAM's 1-cycle synchronous read latency with a 2-entry output buffer, so backpressure never drops or duplicates data.

Parameters:
DATA_W, 8, data width (matches RAM word width)
ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W = 1024

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
start_load  in  1  pulse: begin load at address 0 (honoured only in IDLE)
start_read  in  1  pulse: begin readback of stored block (honoured only in IDLE)
in_valid  in  1  input byte valid
in_data  in  DATA_W  input byte
in_last  in  1  marks final input byte
in_ready  out  1  controller accepts input byte
out_valid  out  1  output byte valid
out_data  out  DATA_W  output byte
out_last  out  1  marks final output byte
out_ready  in  1  downstream accepts output byte
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when a load or read completes
count  out  ADDR_W+1  bytes stored by the last load, range 0..1024
mem_wr  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_d_i  out  DATA_W  RAM write data
mem_d_o  in  DATA_W  RAM read data, valid the cycle after the address is presented

Behaviour:
- Reset (synchronous, rst=1 at a clock edge):
  - state=IDLE.
  - in_ready, out_valid, out_last, busy, done, mem_wr = 0; count=0.
  - Pointers and buffer cleared.
  - RAM contents are not touched.
  - Reset mid-load or mid-read aborts immediately; no done pulse.
- States:
  - IDLE: start_load -> LOAD; start_read -> READ.
    - Both asserted in the same cycle: LOAD wins.
    - start_* asserted outside IDLE: ignored.
  - LOAD:
    - in_ready=1.
    - On in_valid&in_ready: mem_wr=1, mem_addr=wptr, mem_d_i=in_data (combinational, same cycle); wptr++.
    - On entry to LOAD: wptr=0, count=0.
    - Exit to IDLE with a done pulse when the accepted byte has in_last=1, or when the byte written is at address DEPTH-1 (full).
    - count is registered as the number of bytes written (1..1024).
    - in_ready=0 from the cycle after the exit transfer.
    - Bytes after full are never accepted.
  - READ:
    - Entered with rptr=0 and issued=0.
    - If count==0: return to IDLE next cycle with a done pulse; out_valid is never asserted.
    - Otherwise, issue a read (mem_addr=rptr, mem_wr=0; rptr++) only when issued<count and (buffer occupancy + reads in flight) < 2.
    - A read issued in cycle n has mem_d_o captured into the buffer at the edge ending cycle n+1.
    - out_valid = buffer not empty; out_data = head entry.
    - Pop on out_valid&out_ready.
    - out_last=1 on the entry read from address count-1.
    - Exit to IDLE with a done pulse in the cycle after the out_last transfer.
- Latency and throughput:
  - start_read at cycle t: first read issued in cycle t+1; out_valid first high in cycle t+3.
  - With out_ready held 1: one byte per cycle with no bubbles.
  - Load throughput: one byte per cycle.
- Outside LOAD: mem_wr=0.
- Outside READ issue cycles: mem_addr holds its last value; don't-care to the RAM.
- Widths:
  - count is ADDR_W+1 bits so 1024 is representable.
  - Pointers are ADDR_W+1 bits internally; only the low ADDR_W bits drive mem_addr. No wrap occurs.

Test Plan:
- start_load; send 0x11,0x12,0x13,0x14,0x15 with in_last on 0x15 -> RAM[0..4] written; count=5; done pulses once; in_ready=0 afterwards.
- Then start_read with out_ready=1 -> out_data 0x11..0x15 on cycles t+3..t+7; out_last only with 0x15; done pulses at t+8.
- Same readback with out_ready toggling 1,0,0,1,... -> output sequence exactly 0x11..0x15, no loss or duplication; out_data stable while out_valid&!out_ready.
- Load 1024 bytes (value = addr[7:0]) without in_last -> count=1024; in_ready drops after the byte at addr 1023. Readback -> 1024 bytes, out_last on the byte from addr 1023 (0xFF).
- After reset, start_read with count=0 -> no out_valid; done pulses one cycle after entering READ.
- Corner cases:
  - start_load and start_read in the same cycle -> LOAD.
  - rst asserted mid-read after 3 bytes -> next cycle out_valid=0, busy=0, count=0; no done pulse.
